// File: rtl/multdiv_sequencer.sv
// Sequencer between execute and the shared multiply/divide unit.
// Issues one start pulse per op, stalls upstream, hands the result to writeback.
module multdiv_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 5,
    parameter int MIN_LAT = 2,
    parameter int TIMEOUT = 40
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic             op_is_mult,
    input  logic             op_is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAG_W-1:0] op_tag,
    input  logic             flush,
    output logic             md_ctrl_MULT,
    output logic             md_ctrl_DIV,
    output logic [WIDTH-1:0] md_operandA,
    output logic [WIDTH-1:0] md_operandB,
    input  logic [WIDTH-1:0] md_result,
    input  logic             md_exception,
    input  logic             md_resultRDY,
    output logic             stall,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_exception
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_LAT);
    localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_nxt;

    logic             mult_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] data_q;
    logic             exc_q;
    logic [CW-1:0]    cnt_q, cnt_nxt;

    logic legal, accept, rdy_ok, timed_out, busy_live;

    assign legal     = op_valid & (op_is_mult ^ op_is_div);
    assign accept    = legal & ((state_q == IDLE) |
                                ((state_q == DONE) & wb_ready));
    // RDY seen too early may still be left over from the previous op
    assign rdy_ok    = md_resultRDY & (cnt_q >= MIN_C);
    assign timed_out = (cnt_q == TO_C);
    assign busy_live = (state_q == BUSY) & ~flush;

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_nxt = START;
            end
            START: begin
                state_nxt = flush ? IDLE : BUSY;
            end
            BUSY: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = timed_out ? cnt_q : cnt_q + CW'(1);
                    if (rdy_ok || timed_out) state_nxt = DONE;
                end
            end
            DONE: begin
                if (wb_ready) state_nxt = legal ? START : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mult_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            if (accept) begin
                mult_q <= op_is_mult;
                a_q    <= op_a;
                b_q    <= op_b;
                tag_q  <= op_tag;
            end
            if (busy_live) begin
                if (rdy_ok) begin
                    data_q <= md_result;
                    exc_q  <= md_exception;
                end else if (timed_out) begin
                    data_q <= '0;
                    exc_q  <= 1'b1;
                end
            end
        end
    end

    assign md_ctrl_MULT = (state_q == START) & mult_q;
    assign md_ctrl_DIV  = (state_q == START) & ~mult_q;
    assign md_operandA  = a_q;
    assign md_operandB  = b_q;

    assign stall = (state_q == START) | (state_q == BUSY) |
                   ((state_q == DONE) & ~wb_ready);

    assign wb_valid     = (state_q == DONE);
    assign wb_data      = data_q;
    assign wb_tag       = tag_q;
    assign wb_exception = exc_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer with a mock multiply/divide unit.
// Expected results come from a latency/arithmetic model of each operation.
module tb_multdiv_sequencer;

    localparam int WIDTH   = 32;
    localparam int TAG_W   = 5;
    localparam int MIN_LAT = 2;
    localparam int TIMEOUT = 40;

    logic             clock = 0;
    logic             reset_n = 0;
    logic             op_valid = 0;
    logic             op_is_mult = 0;
    logic             op_is_div = 0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic [TAG_W-1:0] op_tag = '0;
    logic             flush = 0;
    logic             md_ctrl_MULT, md_ctrl_DIV;
    logic [WIDTH-1:0] md_operandA, md_operandB;
    logic [WIDTH-1:0] md_result;
    logic             md_exception;
    logic             md_resultRDY;
    logic             stall, wb_valid;
    logic             wb_ready = 0;
    logic [WIDTH-1:0] wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_exception;

    int checks = 0;
    int errors = 0;

    multdiv_sequencer #(
        .WIDTH(WIDTH), .TAG_W(TAG_W),
        .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .op_valid(op_valid), .op_is_mult(op_is_mult),
        .op_is_div(op_is_div), .op_a(op_a), .op_b(op_b),
        .op_tag(op_tag), .flush(flush),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_result(md_result), .md_exception(md_exception),
        .md_resultRDY(md_resultRDY), .stall(stall),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_tag(wb_tag),
        .wb_exception(wb_exception)
    );

    always #5 clock = ~clock;

    // Mock unit: RDY rises rdy_at cycles after the first cycle following the pulse
    logic force_rdy = 0;
    int   rdy_at = 1000;
    int   since = 0;
    logic armed = 0;
    logic mock_div = 0;

    always @(posedge clock) begin
        if (md_ctrl_MULT | md_ctrl_DIV) begin
            since    <= 0;
            armed    <= 1'b1;
            mock_div <= md_ctrl_DIV;
        end else begin
            if (since < 100000) since <= since + 1;
            if (wb_valid) armed <= 1'b0;
        end
    end

    assign md_resultRDY = force_rdy | (armed && since >= rdy_at);

    always_comb begin
        md_exception = 1'b0;
        md_result    = md_operandA * md_operandB;
        if (mock_div) begin
            if (md_operandB == 0) begin
                md_result    = '1;
                md_exception = 1'b1;
            end else begin
                md_result = $signed(md_operandA) / $signed(md_operandB);
            end
        end
    end

    function automatic void model(input logic div, input logic [31:0] a,
                                  input logic [31:0] b, input int rat,
                                  input logic frc, output int n,
                                  output logic [31:0] d, output logic e);
        int k;
        k = frc ? MIN_LAT : (rat > MIN_LAT ? rat : MIN_LAT);
        if (k > TIMEOUT) begin
            n = TIMEOUT + 2;
            d = '0;
            e = 1'b1;
        end else begin
            n = k + 2;
            e = 1'b0;
            if (!div) d = a * b;
            else if (b == 0) begin
                d = '1;
                e = 1'b1;
            end else d = $signed(a) / $signed(b);
        end
    endfunction

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        op_valid = 1; op_is_mult = m; op_is_div = d;
        op_a = a; op_b = b; op_tag = tag;
        @(negedge clock);
        op_valid = 0; op_is_mult = 0; op_is_div = 0;
    endtask

    task automatic wait_valid(output int n, output int stall_lo,
                              output int pulses);
        n = 0; stall_lo = 0; pulses = 0;
        while (!wb_valid && n < 200) begin
            if (!stall) stall_lo++;
            @(negedge clock);
            n++;
            if (md_ctrl_MULT | md_ctrl_DIV) pulses++;
        end
    endtask

    task automatic retire();
        wb_ready = 1;
        @(negedge clock);
        wb_ready = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(negedge clock);
        checks++;
        if ({md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB, stall,
             wb_valid, wb_data, wb_tag, wb_exception} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero wb_data=%h stall=%b",
                     wb_data, stall);
        end
        reset_n = 1;
        @(negedge clock);
    endtask

    task automatic test_mult();
        int n, sl, p;
        force_rdy = 0; rdy_at = 16;
        issue(1, 0, 32'd7, 32'hFFFF_FFFD, 5'd9);
        checks++;
        if ({md_ctrl_MULT, md_ctrl_DIV, stall} !== 3'b101) begin
            errors++;
            $display("FAIL mult_pulse: got mult=%b div=%b stall=%b want 1 0 1",
                     md_ctrl_MULT, md_ctrl_DIV, stall);
        end
        checks++;
        if (md_operandA !== 32'd7 || md_operandB !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL mult_operands: got %h %h", md_operandA, md_operandB);
        end
        wait_valid(n, sl, p);
        checks++;
        if (n !== 18 || sl !== 0 || p !== 0) begin
            errors++;
            $display("FAIL mult_latency: got n=%0d stall_lo=%0d pulses=%0d want 18 0 0",
                     n, sl, p);
        end
        checks++;
        if (wb_data !== 32'hFFFF_FFEB || wb_tag !== 5'd9 ||
            wb_exception !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL mult_result: got %h tag=%0d exc=%b stall=%b want ffffffeb 9 0 1",
                     wb_data, wb_tag, wb_exception, stall);
        end
        wb_ready = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL done_ready_stall: got %b want 0", stall);
        end
        @(negedge clock);
        wb_ready = 0;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL mult_retire: wb_valid got %b want 0", wb_valid);
        end
    endtask

    task automatic test_stale_rdy();
        int n, sl, p;
        force_rdy = 1;
        repeat (2) @(negedge clock);
        issue(1, 0, 32'd12, 32'd11, 5'd4);
        wait_valid(n, sl, p);
        checks++;
        if (n !== MIN_LAT + 2 || wb_data !== 32'd132) begin
            errors++;
            $display("FAIL stale_rdy: got n=%0d data=%0d want %0d 132",
                     n, wb_data, MIN_LAT + 2);
        end
        force_rdy = 0;
        retire();
    endtask

    task automatic test_timeout();
        int n, sl, p;
        rdy_at = 1000;
        issue(0, 1, 32'd50, 32'd5, 5'd17);
        wait_valid(n, sl, p);
        checks++;
        if (n !== TIMEOUT + 2 || wb_data !== 32'd0 ||
            wb_exception !== 1'b1 || wb_tag !== 5'd17) begin
            errors++;
            $display("FAIL timeout: got n=%0d data=%h exc=%b tag=%0d want %0d 0 1 17",
                     n, wb_data, wb_exception, wb_tag, TIMEOUT + 2);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        int n, sl, p, bad;
        rdy_at = 3;
        issue(1, 0, 32'd6, 32'd9, 5'd3);
        wait_valid(n, sl, p);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (wb_valid !== 1 || stall !== 1 || wb_data !== 32'd54 ||
                wb_tag !== 5'd3 || wb_exception !== 0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL backpressure_hold: got %0d unstable cycles want 0", bad);
        end
        wb_ready = 1;
        issue(0, 1, 32'd100, 32'd7, 5'd12);
        wb_ready = 0;
        checks++;
        if (md_ctrl_DIV !== 1 || md_ctrl_MULT !== 0 || wb_valid !== 0) begin
            errors++;
            $display("FAIL b2b_start: got div=%b mult=%b wb_valid=%b want 1 0 0",
                     md_ctrl_DIV, md_ctrl_MULT, wb_valid);
        end
        wait_valid(n, sl, p);
        checks++;
        if (wb_data !== 32'd14 || wb_tag !== 5'd12 || wb_exception !== 0) begin
            errors++;
            $display("FAIL b2b_result: got %0d tag=%0d exc=%b want 14 12 0",
                     wb_data, wb_tag, wb_exception);
        end
        retire();
    endtask

    task automatic test_flush();
        int n, sl, p, seen;
        rdy_at = 8;
        issue(0, 1, 32'd81, 32'd9, 5'd20);
        repeat (6) @(negedge clock);
        flush = 1;
        @(negedge clock);
        flush = 0;
        checks++;
        if (stall !== 0 || wb_valid !== 0) begin
            errors++;
            $display("FAIL flush_idle: got stall=%b wb_valid=%b want 0 0",
                     stall, wb_valid);
        end
        seen = 0;
        repeat (15) begin
            @(negedge clock);
            if (wb_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_no_wb: got %0d valid cycles want 0", seen);
        end
        rdy_at = 5;
        issue(1, 0, 32'd13, 32'd3, 5'd21);
        wait_valid(n, sl, p);
        checks++;
        if (n !== 7 || wb_data !== 32'd39 || wb_tag !== 5'd21) begin
            errors++;
            $display("FAIL flush_next: got n=%0d data=%0d tag=%0d want 7 39 21",
                     n, wb_data, wb_tag);
        end
        retire();
    endtask

    task automatic test_illegal();
        int bad;
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            op_valid = 1; op_is_mult = (i == 0); op_is_div = (i == 0);
            op_a = 32'hDEAD; op_b = 32'hBEEF;
            @(negedge clock);
            op_valid = 0; op_is_mult = 0; op_is_div = 0;
            if (stall || md_ctrl_MULT || md_ctrl_DIV || wb_valid) bad++;
            @(negedge clock);
            if (stall || md_ctrl_MULT || md_ctrl_DIV || wb_valid) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL illegal_ignored: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_async_reset();
        rdy_at = 1000;
        issue(1, 0, 32'd5, 32'd6, 5'd7);
        repeat (3) @(negedge clock);
        reset_n = 0;
        #1;
        checks++;
        if ({md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB, stall,
             wb_valid, wb_data, wb_tag, wb_exception} !== '0) begin
            errors++;
            $display("FAIL async_reset: got stall=%b opA=%h tag=%0d want all 0",
                     stall, md_operandA, wb_tag);
        end
        @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        checks++;
        if (stall !== 0 || wb_valid !== 0) begin
            errors++;
            $display("FAIL reset_idle: got stall=%b wb_valid=%b want 0 0",
                     stall, wb_valid);
        end
    endtask

    task automatic test_random();
        int n, sl, p, en, dly;
        logic m;
        logic [31:0] a, b, ed;
        logic [4:0] tag;
        logic ee;
        for (int i = 0; i < 25; i++) begin
            m   = 1'($urandom % 2);
            a   = $urandom;
            b   = ($urandom % 5 == 0) ? 32'd0 : $urandom % 1000 - 500;
            tag = 5'($urandom);
            force_rdy = ($urandom % 6 == 0);
            rdy_at = $urandom_range(0, 45);
            dly = $urandom_range(0, 3);
            model(!m, a, b, rdy_at, force_rdy, en, ed, ee);
            issue(m, !m, a, b, tag);
            checks++;
            if (md_ctrl_MULT !== m || md_ctrl_DIV !== !m) begin
                errors++;
                $display("FAIL rand_pulse[%0d]: got mult=%b div=%b want %b %b",
                         i, md_ctrl_MULT, md_ctrl_DIV, m, !m);
            end
            wait_valid(n, sl, p);
            checks++;
            if (n !== en || wb_data !== ed || wb_exception !== ee ||
                wb_tag !== tag || sl !== 0) begin
                errors++;
                $display("FAIL rand_result[%0d]: got n=%0d data=%h exc=%b tag=%0d want %0d %h %b %0d",
                         i, n, wb_data, wb_exception, wb_tag, en, ed, ee, tag);
            end
            force_rdy = 0;
            repeat (dly) @(negedge clock);
            retire();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mult();
        test_stale_rdy();
        test_timeout();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
